// File: rtl/riviera_pkg.sv
// Shared register-file types and sizing constants for the integer pipeline.
package riviera_pkg;
   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = $clog2(NREG);
   localparam int PEND_W     = 2;
   localparam int PEND_MAX   = (1 << PEND_W) - 1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [PEND_W-1:0]     pend_cnt_t;
endpackage

// File: rtl/reg_file_wb_if.sv
// Decode/WB-facing bundle of the register file: write-back port, read ports, issue reservation, stall flags.
// master = pipeline side (drives i_*), slave = register file (drives o_*).
interface reg_file_wb_if;
   import riviera_pkg::*;

   reg_addr_t i_wb_wr_reg_addr;
   xlen_t     i_wb_wr_reg_data;
   logic      i_wb_wr_reg_en;
   reg_addr_t i_rs1_addr;
   reg_addr_t i_rs2_addr;
   logic      i_rs1_used;
   logic      i_rs2_used;
   xlen_t     o_rs1_data;
   xlen_t     o_rs2_data;
   logic      i_issue_valid;
   reg_addr_t i_issue_rd;
   logic      i_issue_wr;
   logic      o_issue_ready;
   logic      o_hazard;
   logic      o_err_underflow;

   modport master (
      output i_wb_wr_reg_addr, i_wb_wr_reg_data, i_wb_wr_reg_en,
      output i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used,
      output i_issue_valid, i_issue_rd, i_issue_wr,
      input  o_rs1_data, o_rs2_data, o_issue_ready, o_hazard, o_err_underflow
   );

   modport slave (
      input  i_wb_wr_reg_addr, i_wb_wr_reg_data, i_wb_wr_reg_en,
      input  i_rs1_addr, i_rs2_addr, i_rs1_used, i_rs2_used,
      input  i_issue_valid, i_issue_rd, i_issue_wr,
      output o_rs1_data, o_rs2_data, o_issue_ready, o_hazard, o_err_underflow
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: reserve at issue, release at write-back; hazard/ready are combinational,
// counters update next edge. RF_WB_BYPASS_EN lets the last pending write-back clear busy in its own cycle.
module rf_scoreboard
   import riviera_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      wb_en_i,
   input  reg_addr_t wb_addr_i,
   input  logic      issue_valid_i,
   input  reg_addr_t issue_rd_i,
   input  logic      issue_wr_i,
   input  reg_addr_t rs1_addr_i,
   input  reg_addr_t rs2_addr_i,
   input  logic      rs1_used_i,
   input  logic      rs2_used_i,
   output logic      issue_ready_o,
   output logic      hazard_o,
   output logic      err_underflow_o
);
   pend_cnt_t pend_q [NREG];
   pend_cnt_t pend_d [NREG];
   logic      err_q, err_d;
   logic      drop1, drop2, busy1, busy2;

   // A full counter refuses a new reservation unless a release lands in the same cycle.
   always_comb begin
      issue_ready_o = 1'b1;
      if (issue_wr_i && (issue_rd_i != '0) &&
          (pend_q[issue_rd_i] == pend_cnt_t'(PEND_MAX)) &&
          !(wb_en_i && (wb_addr_i == issue_rd_i)))
         issue_ready_o = 1'b0;
   end

`ifdef RF_WB_BYPASS_EN
   assign drop1 = wb_en_i && (wb_addr_i == rs1_addr_i) && (pend_q[rs1_addr_i] == pend_cnt_t'(1));
   assign drop2 = wb_en_i && (wb_addr_i == rs2_addr_i) && (pend_q[rs2_addr_i] == pend_cnt_t'(1));
`else
   assign drop1 = 1'b0;
   assign drop2 = 1'b0;
`endif

   assign busy1    = (rs1_addr_i != '0) && (pend_q[rs1_addr_i] != '0) && !drop1;
   assign busy2    = (rs2_addr_i != '0) && (pend_q[rs2_addr_i] != '0) && !drop2;
   assign hazard_o = (rs1_used_i && busy1) || (rs2_used_i && busy2);
   assign err_underflow_o = err_q;

   always_comb begin
      logic inc, dec;
      inc   = 1'b0;
      dec   = 1'b0;
      err_d = err_q;
      for (int r = 0; r < NREG; r++) begin
         pend_d[r] = pend_q[r];
         if (r != 0) begin
            inc = issue_valid_i && issue_wr_i && issue_ready_o && (issue_rd_i == reg_addr_t'(r));
            dec = wb_en_i && (wb_addr_i == reg_addr_t'(r));
            if (inc && !dec)
               pend_d[r] = pend_q[r] + 1'b1;
            else if (!inc && dec && (pend_q[r] != '0))
               pend_d[r] = pend_q[r] - 1'b1;
            if (dec && (pend_q[r] == '0))
               err_d = 1'b1;
         end
      end
      pend_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++)
            pend_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++)
            pend_q[r] <= pend_d[r];
         err_q <= err_d;
      end
   end
endmodule

// File: rtl/reg_file_wb.sv
// Integer register file (x0 = 0) with WB write port, two combinational read ports and RAW scoreboard.
// Writes land on the next edge; RF_WB_BYPASS_EN forwards WB data to reads in the write cycle.
module reg_file_wb
   import riviera_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   reg_file_wb_if.slave  bus
);
   xlen_t regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++)
            regs_q[r] <= '0;
      end else if (bus.i_wb_wr_reg_en && (bus.i_wb_wr_reg_addr != '0)) begin
         regs_q[bus.i_wb_wr_reg_addr] <= bus.i_wb_wr_reg_data;
      end
   end

   always_comb begin
      bus.o_rs1_data = (bus.i_rs1_addr == '0) ? '0 : regs_q[bus.i_rs1_addr];
      bus.o_rs2_data = (bus.i_rs2_addr == '0) ? '0 : regs_q[bus.i_rs2_addr];
`ifdef RF_WB_BYPASS_EN
      if (bus.i_wb_wr_reg_en && (bus.i_rs1_addr != '0) && (bus.i_wb_wr_reg_addr == bus.i_rs1_addr))
         bus.o_rs1_data = bus.i_wb_wr_reg_data;
      if (bus.i_wb_wr_reg_en && (bus.i_rs2_addr != '0) && (bus.i_wb_wr_reg_addr == bus.i_rs2_addr))
         bus.o_rs2_data = bus.i_wb_wr_reg_data;
`endif
   end

   rf_scoreboard u_sb (
      .clk             (clk),
      .rst_n           (rst_n),
      .wb_en_i         (bus.i_wb_wr_reg_en),
      .wb_addr_i       (bus.i_wb_wr_reg_addr),
      .issue_valid_i   (bus.i_issue_valid),
      .issue_rd_i      (bus.i_issue_rd),
      .issue_wr_i      (bus.i_issue_wr),
      .rs1_addr_i      (bus.i_rs1_addr),
      .rs2_addr_i      (bus.i_rs2_addr),
      .rs1_used_i      (bus.i_rs1_used),
      .rs2_used_i      (bus.i_rs2_used),
      .issue_ready_o   (bus.o_issue_ready),
      .hazard_o        (bus.o_hazard),
      .err_underflow_o (bus.o_err_underflow)
   );
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed scenarios then constrained-random traffic against a reference model.
module tb_reg_file_wb;
   import riviera_pkg::*;

`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      bit          wen;
      int          wa;
      logic [31:0] wd;
      int          rs1, rs2;
      bit          u1, u2, iv;
      int          ird;
      bit          iwr;
   } stim_t;

   typedef struct {
      logic [31:0] d1, d2;
      bit          haz, rdy, err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   reg_file_wb_if bus ();
   reg_file_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t        q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_regs [32];
   int          m_pend [32];
   bit          m_err;
   stim_t       cur;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic logic [31:0] rd_model(int a, stim_t s);
      if (a == 0) return 32'd0;
      if (BYP && s.wen && s.wa == a) return s.wd;
      return m_regs[a];
   endfunction

   function automatic bit busy_model(int r, stim_t s);
      if (r == 0 || m_pend[r] == 0) return 1'b0;
      if (BYP && m_pend[r] == 1 && s.wen && s.wa == r) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit ready_model(stim_t s);
      return !(s.iwr && s.ird != 0 && m_pend[s.ird] == PEND_MAX && !(s.wen && s.wa == s.ird));
   endfunction

   function automatic exp_t expect_of(stim_t s);
      exp_t e;
      e.d1  = rd_model(s.rs1, s);
      e.d2  = rd_model(s.rs2, s);
      e.haz = (s.u1 && busy_model(s.rs1, s)) || (s.u2 && busy_model(s.rs2, s));
      e.rdy = ready_model(s);
      e.err = m_err;
      return e;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 32'd0;
         m_pend[r] = 0;
      end
      m_err = 1'b0;
   endtask

   // Effect of one clock edge on the architectural state.
   task automatic commit(stim_t s);
      bit acc, dec;
      acc = s.iv && s.iwr && s.ird != 0 && ready_model(s);
      dec = s.wen && s.wa != 0;
      if (dec && m_pend[s.wa] == 0) m_err = 1'b1;
      if (dec) m_regs[s.wa] = s.wd;
      if (acc) m_pend[s.ird] = m_pend[s.ird] + 1;
      if (dec && m_pend[s.wa] > 0) m_pend[s.wa] = m_pend[s.wa] - 1;
   endtask

   task automatic apply(stim_t s);
      bus.i_wb_wr_reg_en   = s.wen;
      bus.i_wb_wr_reg_addr = reg_addr_t'(s.wa);
      bus.i_wb_wr_reg_data = s.wd;
      bus.i_rs1_addr       = reg_addr_t'(s.rs1);
      bus.i_rs2_addr       = reg_addr_t'(s.rs2);
      bus.i_rs1_used       = s.u1;
      bus.i_rs2_used       = s.u2;
      bus.i_issue_valid    = s.iv;
      bus.i_issue_rd       = reg_addr_t'(s.ird);
      bus.i_issue_wr       = s.iwr;
   endtask

   function automatic stim_t gen();
      stim_t s;
      int    start;
      s     = idle();
      s.wen = 1'($urandom_range(0, 1));
      s.wa  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
         start = s.wa;
         for (int k = 0; k < 16; k++)
            if (m_pend[(start + k) % 16] > 0 && (start + k) % 16 != 0) begin
               s.wa = (start + k) % 16;
               break;
            end
      end
      s.wd  = $urandom;
      s.rs1 = $urandom_range(0, 15);
      s.rs2 = $urandom_range(0, 15);
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.ird = $urandom_range(0, 15);
      s.iwr = ($urandom_range(0, 4) != 0);
      // Decode never issues while stalled.
      if (!expect_of(s).haz) s.iv = 1'($urandom_range(0, 1));
      return s;
   endfunction

   task automatic step(bit rnd, stim_t s);
      @(posedge clk);
      if (rst_n) commit(cur);
      #1;
      cur = rnd ? gen() : s;
      apply(cur);
      q.push_back(expect_of(cur));
   endtask

   task automatic drive(stim_t s);
      step(1'b0, s);
   endtask

   // Reset asserted mid-cycle, released mid-cycle one clock later.
   task automatic do_reset();
      @(posedge clk);
      if (rst_n) commit(cur);
      #1;
      cur = idle();
      apply(cur);
      #1;
      rst_n = 1'b0;
      model_reset();
      q.push_back(expect_of(cur));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.push_back(expect_of(cur));
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, ex, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         check("rs1_data",     bus.o_rs1_data,              mon_e.d1);
         check("rs2_data",     bus.o_rs2_data,              mon_e.d2);
         check("hazard",       {31'd0, bus.o_hazard},       {31'd0, mon_e.haz});
         check("issue_ready",  {31'd0, bus.o_issue_ready},  {31'd0, mon_e.rdy});
         check("err_underflow",{31'd0, bus.o_err_underflow},{31'd0, mon_e.err});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      model_reset();
      cur = idle();
      apply(cur);
      do_reset();

      s = idle(); s.rs1 = 5; s.rs2 = 0; s.u1 = 1; s.u2 = 1; drive(s);

      s = idle(); s.wen = 1; s.wa = 7; s.wd = 32'hDEADBEEF; drive(s);
      s = idle(); s.rs1 = 7; drive(s);
      s = idle(); s.wen = 1; s.wa = 0; s.wd = 32'h1234; s.rs1 = 0; drive(s);
      s = idle(); s.rs1 = 0; s.rs2 = 7; drive(s);
      do_reset();

      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 3; drive(s);
      s = idle(); s.rs1 = 3; s.u1 = 1; drive(s);
      s = idle(); s.rs1 = 3; s.u1 = 1; s.wen = 1; s.wa = 3; s.wd = 32'h55; drive(s);
      s = idle(); s.rs1 = 3; s.u1 = 1; drive(s);

      for (int i = 0; i < 3; i++) begin
         s = idle(); s.iv = 1; s.iwr = 1; s.ird = 9; drive(s);
      end
      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 9; drive(s);
      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 9; drive(s);
      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 9; s.wen = 1; s.wa = 9; s.wd = 32'h99; drive(s);
      s = idle(); s.rs1 = 9; s.u1 = 1; s.iwr = 1; s.ird = 9; drive(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.wen = 1; s.wa = 9; s.wd = 32'h900 + i; s.rs2 = 9; s.u2 = 1; drive(s);
      end

      do_reset();
      s = idle(); s.wen = 1; s.wa = 12; s.wd = 32'h77; drive(s);
      s = idle(); s.rs1 = 12; drive(s);
      s = idle(); s.rs2 = 12; drive(s);
      do_reset();
      s = idle(); s.rs1 = 12; drive(s);

      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 4; drive(s);
      s = idle(); s.iv = 1; s.iwr = 1; s.ird = 4; s.wen = 1; s.wa = 4; s.wd = 32'h44; drive(s);
      s = idle(); s.rs2 = 4; s.u2 = 1; drive(s);
      s = idle(); s.wen = 1; s.wa = 4; s.wd = 32'h45; s.rs2 = 4; s.u2 = 1; drive(s);
      s = idle(); s.rs2 = 4; s.u2 = 1; drive(s);

      for (int n = 0; n < 1500; n++) begin
         if (n % 400 == 399) do_reset();
         step(1'b1, s);
      end

      @(posedge clk);
      #1;
      cur = idle();
      apply(cur);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d expected=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file that receives the write-back port (addr/data/en) driven by the WB stage.
- Serves two combinational read ports to decode.
- Holds a per-register pending-write scoreboard. Decode reserves a destination at issue; WB releases it on write-back.
- Raises a RAW hazard stall toward the pipeline staller logic.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- PEND_W, 2, width of each per-register pending counter; max in-flight writers per register = 2^PEND_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_wb_wr_reg_addr  in  $clog2(NREG)  WB destination register.
- i_wb_wr_reg_data  in  XLEN  WB write data.
- i_wb_wr_reg_en  in  1  WB write strobe.
- i_rs1_addr  in  $clog2(NREG)  read port 1 address.
- i_rs2_addr  in  $clog2(NREG)  read port 2 address.
- i_rs1_used  in  1  current decode instruction reads rs1.
- i_rs2_used  in  1  current decode instruction reads rs2.
- o_rs1_data  out  XLEN  read port 1 data.
- o_rs2_data  out  XLEN  read port 2 data.
- i_issue_valid  in  1  decode issues an instruction this cycle.
- i_issue_rd  in  $clog2(NREG)  destination of the issuing instruction.
- i_issue_wr  in  1  issuing instruction writes rd.
- o_issue_ready  out  1  reservation of i_issue_rd is accepted.
- o_hazard  out  1  RAW hazard on a used source; decode must stall.
- o_err_underflow  out  1  sticky: a WB write hit a register with no pending reservation.

Behaviour:
- Reset (async assert, sync release):
  - All registers 0; all pending counters 0; o_err_underflow 0.
  - Combinational outputs follow from this state: o_hazard 0, o_issue_ready 1.
- Write:
  - On posedge with i_wb_wr_reg_en=1 and addr!=0, reg[addr] <= data.
  - Writes to x0 are discarded.
- Read:
  - o_rsN_data is combinational from the register array.
  - Address 0 always returns 0.
  - Read-during-write behaviour: see Optional Feature.
- Scoreboard, per register r != 0:
  - inc = i_issue_valid & i_issue_wr & o_issue_ready & (i_issue_rd==r).
  - dec = i_wb_wr_reg_en & (i_wb_wr_reg_addr==r).
  - inc & !dec: pend+1. !inc & dec & pend>0: pend-1. inc & dec: unchanged.
  - dec with pend==0: pend stays 0; o_err_underflow <= 1 (sticky until reset); the data write still occurs.
  - Register 0 is never reserved; its counter is constant 0.
- o_issue_ready = 0 only when i_issue_wr=1, i_issue_rd!=0, pend[i_issue_rd]==max, and there is no same-cycle dec on that register. Otherwise it is 1.
- An issue with o_issue_ready=0 changes no state; decode must hold and retry.
- o_hazard = (i_rs1_used & busy(rs1)) | (i_rs2_used & busy(rs2)).
  - busy(r) = r!=0 & pend[r]!=0, modified by the Optional Feature.
- o_hazard does not gate the issue reservation; decode must not assert i_issue_valid while o_hazard=1.
- Latency:
  - Write visible to normal reads 1 cycle after the strobe.
  - Scoreboard change visible the cycle after the issue/dec edge.
- Reset mid-operation: all pending reservations are dropped. The pipeline is reset concurrently, so no underflow flag is set afterward.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Write-through bypass: if i_wb_wr_reg_en and i_wb_wr_reg_addr==rsN!=0, o_rsN_data = i_wb_wr_reg_data in the same cycle.
  - busy(r) additionally excludes pend[r]==1 with a same-cycle dec on r, so the hazard drops in the WB cycle.
- Undefined:
  - Reads return the pre-write array value.
  - busy(r) uses the registered pend only, so the hazard clears one cycle after write-back.

Decomposition:
- Shared package (riviera_pkg) holds:
  - XLEN, NREG, REG_ADDR_W constants.
  - typedef reg_addr_t, typedef xlen_t.
  - typedef pend_cnt_t (logic [PEND_W-1:0]).
- One sub-module, rf_scoreboard:
  - Contains the counter array, issue_ready, busy and underflow logic.
  - reg_file_wb instantiates it alongside the data array and read muxes.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> o_rs1_data=0, o_rs2_data=0, o_hazard=0, o_issue_ready=1, o_err_underflow=0.
- Write x7=0xDEADBEEF, next cycle read rs1=7 -> 0xDEADBEEF.
  - Write x0=0x1234, read rs1=0 -> 0.
- Issue rd=3; next cycle rs1=3 with used=1 -> o_hazard=1. WB writes x3=0x55:
  - with RF_WB_BYPASS_EN: o_hazard=0 and o_rs1_data=0x55 in the WB cycle;
  - without: o_hazard=1 in the WB cycle, 0 and 0x55 the cycle after.
- Issue rd=9 three times (PEND_W=2) -> pend=3; 4th issue to rd=9 -> o_issue_ready=0, pend stays 3.
  - 4th issue with a same-cycle WB to x9 -> o_issue_ready=1, pend stays 3.
- WB write x12=0x77 with no reservation -> reg[12]=0x77, o_err_underflow=1 and it stays 1.
  - Assert rst_n=0 mid-cycle -> flag, registers and counters clear immediately.
- Same-cycle issue rd=4 and WB to x4 with pend[4]=1 -> pend stays 1.
  - Then rs2=4 with used=1 -> o_hazard=1.
